// File: rtl/mul16_pkg.sv
// Shared types and constants for the 16x16 sequencer driving the 8x8 cs/rdy multiplier.
package mul16_pkg;

  typedef enum logic [2:0] {
    ST_RESYNC  = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam int PP_CNT         = 4;
  localparam int BYTE_W         = 8;
  localparam int TMO_DEF        = 8;
  localparam int RESYNC_CYC_DEF = 3;

  // Shift of each partial product into the 32-bit accumulator: {0, 8, 8, 16}.
  function automatic logic [4:0] pp_shift(input logic [1:0] idx);
    case (idx)
      2'd0:    return 5'd0;
      2'd1:    return 5'd8;
      2'd2:    return 5'd8;
      2'd3:    return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  // Operand a uses its high byte for idx 2/3, operand b for idx 1/3.
  function automatic logic a_hi(input logic [1:0] idx);
    return idx[1];
  endfunction

  function automatic logic b_hi(input logic [1:0] idx);
    return idx[0];
  endfunction

endpackage

// File: rtl/mul16_acc.sv
// Byte selection for the 8x8 multiplier operands and the shift-accumulate of partial products.
module mul16_acc
  import mul16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [1:0]        sel_idx,
  input  logic [1:0]        add_idx,
  input  logic [15:0]       src_a,
  input  logic [15:0]       src_b,
  input  logic [15:0]       pp,
  output logic [BYTE_W-1:0] byte_a,
  output logic [BYTE_W-1:0] byte_b,
  output logic [31:0]       acc_r
);

  logic [31:0] pp_ext_s;

  // Operand byte selection and shifted, zero-extended partial product.
  always_comb begin
    byte_a   = a_hi(sel_idx) ? src_a[15:8] : src_a[7:0];
    byte_b   = b_hi(sel_idx) ? src_b[15:8] : src_b[7:0];
    pp_ext_s = {16'h0000, pp} << pp_shift(add_idx);
  end

  // Accumulator; cleared on request accept, added to only in the capture cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= 32'h0000_0000;
    end else if (clr) begin
      acc_r <= 32'h0000_0000;
    end else if (add) begin
      acc_r <= acc_r + pp_ext_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/mul16_seq.sv
// 16x16 unsigned multiply built from four byte-wide partial products issued to an 8x8 cs/rdy multiplier.
module mul16_seq
  import mul16_pkg::*;
#(
  parameter int TMO        = TMO_DEF,
  parameter int RESYNC_CYC = RESYNC_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        err,
  output logic        mul_cs,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [15:0] mul_result,
  input  logic        mul_rdy
);

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
  localparam logic [7:0] RS_LAST  = 8'(RESYNC_CYC - 1);
  localparam logic [1:0] IDX_LAST = 2'(PP_CNT - 1);

  state_t            state_r, state_nxt_s;
  logic [1:0]        idx_r, idx_nxt_s;
  logic [7:0]        tmo_cnt_r, tmo_cnt_nxt_s;
  logic [7:0]        rs_cnt_r, rs_cnt_nxt_s;
  logic [15:0]       opa_r, opb_r;
  logic              resync_pend_r, launch_pend_r;
  logic              accept_s, add_s, timeout_s;
  logic [15:0]       src_a_s, src_b_s;
  logic [BYTE_W-1:0] sel_a_s, sel_b_s;
  logic [31:0]       acc_s;

  mul16_acc u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept_s),
    .add     (add_s),
    .sel_idx (idx_nxt_s),
    .add_idx (idx_r),
    .src_a   (src_a_s),
    .src_b   (src_b_s),
    .pp      (mul_result),
    .byte_a  (sel_a_s),
    .byte_b  (sel_b_s),
    .acc_r   (acc_s)
  );

  // Next-state logic; the first ISSUE after IDLE must select from the live inputs.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    tmo_cnt_nxt_s = tmo_cnt_r;
    rs_cnt_nxt_s  = rs_cnt_r;
    accept_s      = 1'b0;
    add_s         = 1'b0;
    timeout_s     = 1'b0;
    src_a_s       = (state_r == ST_IDLE) ? op_a : opa_r;
    src_b_s       = (state_r == ST_IDLE) ? op_b : opb_r;
    case (state_r)
      ST_RESYNC: begin
        if (rs_cnt_r == RS_LAST) begin
          rs_cnt_nxt_s = 8'd0;
          state_nxt_s  = launch_pend_r ? ST_ISSUE : ST_IDLE;
        end else begin
          rs_cnt_nxt_s = rs_cnt_r + 8'd1;
        end
      end
      ST_IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          idx_nxt_s    = 2'd0;
          rs_cnt_nxt_s = 8'd0;
          state_nxt_s  = resync_pend_r ? ST_RESYNC : ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tmo_cnt_nxt_s = 8'd0;
        state_nxt_s   = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!mul_rdy) begin
          tmo_cnt_nxt_s = 8'd0;
          state_nxt_s   = ST_WAIT_HI;
        end else if (tmo_cnt_r == TMO_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
        end
      end
      ST_WAIT_HI: begin
        if (mul_rdy) begin
          add_s       = 1'b1;
          state_nxt_s = ST_NEXT;
        end else if (tmo_cnt_r == TMO_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
        end
      end
      ST_NEXT: begin
        if (idx_r == IDX_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          idx_nxt_s   = idx_r + 2'd1;
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_RESYNC;
      end
    endcase
  end

  // State, counters, latched operands and the post-timeout resync bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RESYNC;
      idx_r         <= 2'd0;
      tmo_cnt_r     <= 8'd0;
      rs_cnt_r      <= 8'd0;
      opa_r         <= 16'h0000;
      opb_r         <= 16'h0000;
      resync_pend_r <= 1'b0;
      launch_pend_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
      rs_cnt_r  <= rs_cnt_nxt_s;
      if (accept_s) begin
        opa_r <= op_a;
        opb_r <= op_b;
      end
      if (timeout_s) begin
        resync_pend_r <= 1'b1;
      end else if (accept_s) begin
        resync_pend_r <= 1'b0;
      end
      // A request accepted while a resync is owed launches when RESYNC ends.
      if (accept_s) begin
        launch_pend_r <= resync_pend_r;
      end else if (state_r == ST_RESYNC && state_nxt_s != ST_RESYNC) begin
        launch_pend_r <= 1'b0;
      end
    end
  end

  // Registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b1;
      done    <= 1'b0;
      product <= 32'h0000_0000;
      err     <= 1'b0;
      mul_cs  <= 1'b0;
      mul_a   <= 16'h0000;
      mul_b   <= 16'h0000;
    end else begin
      busy   <= (state_nxt_s != ST_IDLE);
      done   <= (state_nxt_s == ST_DONE);
      mul_cs <= (state_nxt_s == ST_ISSUE);
      if (state_nxt_s == ST_ISSUE) begin
        mul_a <= {8'h00, sel_a_s};
        mul_b <= {8'h00, sel_b_s};
      end
      if (accept_s) begin
        err <= 1'b0;
      end else if (timeout_s) begin
        err <= 1'b1;
      end
      if (state_r != ST_DONE && state_nxt_s == ST_DONE) begin
        product <= timeout_s ? 32'h0000_0000 : acc_s;
      end
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq with a behavioural 8x8 cs/rdy multiplier downstream.
module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] op_a, op_b;
  logic        busy, done, err, mul_cs, mul_rdy;
  logic [31:0] product;
  logic [15:0] mul_a, mul_b, mul_result;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul16_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .err        (err),
    .mul_cs     (mul_cs),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .mul_rdy    (mul_rdy)
  );

  // Non-resettable multiplier: idle (rdy=1) -> busy (rdy=0) -> result (rdy=1). stuck keeps it idle.
  int   mst   = 0;
  logic stuck = 1'b0;
  always @(posedge clk) begin
    if (stuck) mst <= 0;
    else begin
      case (mst)
        0:       if (mul_cs) mst <= 1;
        1:       mst <= 2;
        default: mst <= 0;
      endcase
    end
  end
  assign mul_rdy    = (mst != 1);
  assign mul_result = (mst == 2) ? ({8'h00, mul_a[7:0]} * {8'h00, mul_b[7:0]}) : 16'hDEAD;

  typedef struct {
    logic [31:0] p;
    logic        e;
    int          lat;
    int          cs;
    int          acc;
  } exp_t;
  exp_t        sbq[$];
  logic [31:0] cs_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks operand stability.
  initial begin
    int          cs_cnt = 0;
    logic [15:0] cap_a = 16'h0000;
    logic [15:0] cap_b = 16'h0000;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) cs_cnt = 0;
      else begin
        if (mul_cs) begin
          cs_cnt++;
          cap_a = mul_a;
          cap_b = mul_b;
          cs_log.push_back({mul_a, mul_b});
        end
        if (mst == 2) begin
          chk("mul_a_stable", {16'h0, mul_a}, {16'h0, cap_a});
          chk("mul_b_stable", {16'h0, mul_b}, {16'h0, cap_b});
        end
        if (done) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
          end else begin
            e = sbq.pop_front();
            chk("product", product, e.p);
            chk("err", {31'h0, err}, {31'h0, e.e});
            chk("cs_pulses", cs_cnt, e.cs);
            if (e.lat > 0) chk("latency", cyc - e.acc + 1, e.lat);
          end
          cs_cnt = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 80) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_wait: got busy=1 after %0d cycles, expected 0", k);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    wait_idle();
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p,
                        input logic e, input int lat, input int cs);
    issue(a, b);
    sbq.push_back('{p, e, lat, cs, cyc});
  endtask

  logic [31:0] exp_seq[4] = '{32'h0034_0078, 32'h0034_0056, 32'h0012_0078, 32'h0012_0056};

  initial begin
    rst = 1'b1; start = 1'b0; op_a = 16'h0000; op_b = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_product", product, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_mul_cs", {31'h0, mul_cs}, 32'h0);
    chk("rst_mul_a", {16'h0, mul_a}, 32'h0);
    chk("rst_mul_b", {16'h0, mul_b}, 32'h0);
    rst = 1'b0;

    run_op(16'h0003, 16'h0005, 32'h0000_000F, 1'b0, 17, 4);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 17, 4);

    wait_idle();
    cs_log.delete();
    run_op(16'h1234, 16'h5678, 32'h0626_0060, 1'b0, 17, 4);
    wait_idle();
    chk("seq_len", cs_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("seq_ab", (i < cs_log.size()) ? cs_log[i] : 32'hFFFF_FFFF, exp_seq[i]);

    // Second start in cycle 5 of a busy operation must be dropped.
    run_op(16'h0102, 16'h0304, 32'h0003_0A08, 1'b0, 17, 4);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;

    // Multiplier never drops rdy: timeout, then a clean retry through RESYNC.
    wait_idle();
    stuck = 1'b1;
    run_op(16'h0003, 16'h0005, 32'h0, 1'b1, 0, 1);
    wait_idle();
    stuck = 1'b0;
    run_op(16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b0, 20, 4);

    // Reset during WAIT_HI of idx 2 (cycle 11 after accept).
    issue(16'h1234, 16'h5678);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_mul_a", {16'h0, mul_a}, 32'h0000_0012);
    chk("abort_mul_b", {16'h0, mul_b}, 32'h0000_0078);
    chk("abort_rdy", {31'h0, mul_rdy}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy0", {31'h0, busy}, 32'h1);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_product", product, 32'h0);
    chk("abort_err", {31'h0, err}, 32'h0);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_resync_busy", {31'h0, busy}, 32'h1);
    end
    @(posedge clk); #1;
    chk("abort_idle", {31'h0, busy}, 32'h0);
    run_op(16'h0007, 16'h0009, 32'h0000_003F, 1'b0, 17, 4);

    begin
      int k = 0;
      while ((sbq.size() != 0 || busy) && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 time units, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Upstream sequencer for the 8x8 cs/rdy multiplier unit (`mul`).
- Builds a full 16x16 unsigned product by issuing four byte-wide partial products to the multiplier, then shift-accumulates them into a 32-bit result.
- Sits between the CPU control/ALU dispatch and `mul`: it drives `mul` operands and `cs`, and consumes `mul`'s `result` and `rdy`.

Parameters:
- TMO, 8: max cycles allowed in either wait state before aborting with err.
- RESYNC_CYC, 3: cycles after reset during which cs is held low so a non-resettable mul returns to idle.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only in IDLE.
- op_a  in  16  multiplicand; captured on the start-accept edge.
- op_b  in  16  multiplier; captured on the start-accept edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when product/err is final.
- product  out  32  unsigned op_a*op_b; held until the next start accept.
- err  out  1  multiplier handshake timeout; held until the next start accept.
- mul_cs  out  1  chip select to mul; one-cycle pulse only.
- mul_a  out  16  {8'h00, selected op_a byte}.
- mul_b  out  16  {8'h00, selected op_b byte}.
- mul_result  in  16  8x8 product from mul; valid only in the cycle after mul_rdy has gone low then high.
- mul_rdy  in  1  mul ready; high both when idle and on result.

Behaviour:
- Reset values: busy=1 (RESYNC), done=0, product=0, err=0, mul_cs=0, mul_a=0, mul_b=0. Internal: idx=0, acc=0, tmo_cnt=0.
- Reset has priority over everything, including start in the same cycle.
- Reset mid-operation aborts immediately. No done pulse; product and err are cleared.
- States and transitions:
  - RESYNC: cs=0 for RESYNC_CYC cycles, then go to IDLE.
  - IDLE: busy=0. If start=1, latch op_a/op_b, clear acc/idx/err, go to ISSUE.
  - ISSUE: mul_cs=1 for exactly one cycle; mul_a/mul_b driven per idx; go to WAIT_LO.
  - WAIT_LO: hold operands. If mul_rdy=0, go to WAIT_HI.
  - WAIT_HI: hold operands. If mul_rdy=1, acc += zero-extended mul_result << shift(idx), then go to NEXT.
  - NEXT: cs=0 for one guard cycle. If idx=3 go to DONE, else idx+1 and go to ISSUE.
  - DONE: product<=acc, done=1 for one cycle, go to IDLE.
- Partial-product order by idx:
  - 0: a[7:0]*b[7:0], shift 0.
  - 1: a[7:0]*b[15:8], shift 8.
  - 2: a[15:8]*b[7:0], shift 8.
  - 3: a[15:8]*b[15:8], shift 16.
- Accumulate at 32 bits. The sum never overflows for 16x16 unsigned operands.
- mul_a/mul_b stay stable from ISSUE through WAIT_HI. mul samples operands during its result state.
- Latency with a compliant mul: 4 cycles per partial product, 16 cycles total. done is high in the 17th cycle after the start-accept edge; busy is high for 17 cycles.
- Timeout: tmo_cnt clears on entry to WAIT_LO and WAIT_HI and increments each cycle there. When tmo_cnt reaches TMO: err=1, product=0, done pulses, return to IDLE. The next request first passes RESYNC (RESYNC_CYC cycles) before ISSUE.
- start asserted while busy is ignored; it is not queued.
- mul_result is never sampled outside the WAIT_HI capture cycle, because mul drives Z when idle.

Decomposition:
- Shared package mul16_pkg holds:
  - state enum (RESYNC, IDLE, ISSUE, WAIT_LO, WAIT_HI, NEXT, DONE);
  - PP_CNT=4 and BYTE_W=8;
  - the shift lookup {0, 8, 8, 16};
  - default TMO and RESYNC_CYC.
- One sub-module is natural: mul16_acc (byte select plus shift-accumulate, cleared on start). The FSM stays in the top.
- The bench instantiates the real mul as the downstream model.

Test Plan:
- Reset, then start with op_a=16'h0003, op_b=16'h0005 -> done at cycle 17, product=32'h0000000F, err=0, exactly four mul_cs pulses.
- op_a=16'hFFFF, op_b=16'hFFFF -> product=32'hFFFE0001.
- op_a=16'h1234, op_b=16'h5678 -> product=32'h06260060; mul_a/mul_b sequence 34/78, 34/56, 12/78, 12/56.
- start pulsed again at cycle 5 of a busy operation -> ignored; a single done; product matches the first operands.
- Mul stub holding rdy=1 forever -> after TMO=8 cycles in WAIT_LO: done pulse, err=1, product=0; next start passes RESYNC and succeeds.
- rst asserted in WAIT_HI of idx=2 -> no done; busy=1 for 3 RESYNC cycles, then idle; the following 7*9 request yields product=63.
